// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine coin/credit front-end.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_REFUND  = 2'd3
  } vm_state_e;

  localparam logic [1:0] PROD_A = 2'b00;
  localparam logic [1:0] PROD_B = 2'b01;
  localparam logic [1:0] PROD_C = 2'b10;
  localparam logic [1:0] PROD_D = 2'b11;

  localparam int COIN_VALUE_5  = 5;
  localparam int COIN_VALUE_10 = 10;

  localparam int DEF_PRICE_0        = 5;
  localparam int DEF_PRICE_1        = 10;
  localparam int DEF_PRICE_2        = 15;
  localparam int DEF_PRICE_3        = 20;
  localparam int DEF_CREDIT_W       = 5;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/vm_coin_credit_if.sv
// Vend request channel from the coin/credit front-end to the vending stage.
// Handshake: a transfer happens on a rising edge where vend_valid && vend_ready;
// the master holds vend_valid and vend_product stable until that edge and
// never withdraws a request; the slave may drive vend_ready at any time.
interface vm_coin_credit_if;
  logic       vend_valid;
  logic [1:0] vend_product;
  logic       vend_ready;

  modport master (output vend_valid, output vend_product, input vend_ready);
  modport slave  (input vend_valid, input vend_product, output vend_ready);
endinterface

// File: rtl/vm_price_lut.sv
// Combinational product-code to price lookup, sized to the credit register.
module vm_price_lut
  import vm_pkg::*;
#(
  parameter int CREDIT_W = DEF_CREDIT_W,
  parameter int PRICE_0  = DEF_PRICE_0,
  parameter int PRICE_1  = DEF_PRICE_1,
  parameter int PRICE_2  = DEF_PRICE_2,
  parameter int PRICE_3  = DEF_PRICE_3
) (
  input  logic [1:0]          product,
  output logic [CREDIT_W-1:0] price
);

  always_comb begin
    price = CREDIT_W'(PRICE_0);
    unique case (product)
      PROD_A:  price = CREDIT_W'(PRICE_0);
      PROD_B:  price = CREDIT_W'(PRICE_1);
      PROD_C:  price = CREDIT_W'(PRICE_2);
      PROD_D:  price = CREDIT_W'(PRICE_3);
      default: price = CREDIT_W'(PRICE_0);
    endcase
  end

endmodule

// File: rtl/vm_coin_credit.sv
// Coin/credit front-end: collects coins, issues one vend request per purchase and
// returns surplus/cancelled credit as 5-rupee pulses. VM_COIN_TIMEOUT_EN adds an idle-collect timeout.
module vm_coin_credit
  import vm_pkg::*;
#(
  parameter int PRICE_0        = DEF_PRICE_0,
  parameter int PRICE_1        = DEF_PRICE_1,
  parameter int PRICE_2        = DEF_PRICE_2,
  parameter int PRICE_3        = DEF_PRICE_3,
  parameter int CREDIT_W       = DEF_CREDIT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin5,
  input  logic                coin10,
  input  logic                sel_valid,
  input  logic [1:0]          sel_product,
  input  logic                cancel,
  vm_coin_credit_if.master    vend,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output vm_state_e           dbg_state
);

  if (TIMEOUT_CYCLES < 2 || CREDIT_W < 5) begin : g_bad_cfg
    $error("vm_coin_credit: TIMEOUT_CYCLES must be >= 2 and CREDIT_W >= 5");
  end

  vm_state_e           state, state_n;
  logic [CREDIT_W-1:0] credit_n, price, coin_sum, credit_plus;
  logic [1:0]          product_n;
  logic                coin_any, handshake, timeout;

  vm_price_lut #(
    .CREDIT_W (CREDIT_W),
    .PRICE_0  (PRICE_0),
    .PRICE_1  (PRICE_1),
    .PRICE_2  (PRICE_2),
    .PRICE_3  (PRICE_3)
  ) u_price (
    .product (vend.vend_product),
    .price   (price)
  );

  assign coin_any    = coin5 | coin10;
  assign coin_sum    = (coin5  ? CREDIT_W'(COIN_VALUE_5)  : '0)
                     + (coin10 ? CREDIT_W'(COIN_VALUE_10) : '0);
  assign credit_plus = credit + coin_sum;
  assign handshake   = vend.vend_valid & vend.vend_ready;
  assign dbg_state   = state;

`ifdef VM_COIN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  // Held at zero outside COLLECT, so entering COLLECT always starts a fresh window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              to_cnt <= '0;
    else if (state != ST_COLLECT || coin_any) to_cnt <= '0;
    else                                     to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state == ST_COLLECT) && !coin_any
                && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    credit_n  = credit;
    product_n = vend.vend_product;
    unique case (state)
      ST_IDLE: begin
        if (sel_valid) begin
          state_n   = ST_COLLECT;
          product_n = sel_product;
        end
      end
      ST_COLLECT: begin
        credit_n = credit_plus;
        // Cancel wins over reaching the price; a coin in the same cycle is refunded too.
        if (cancel)                    state_n = (credit_plus == '0) ? ST_IDLE : ST_REFUND;
        else if (credit_plus >= price) state_n = ST_VEND;
        else if (timeout)              state_n = (credit == '0) ? ST_IDLE : ST_REFUND;
      end
      ST_VEND: begin
        if (handshake) begin
          credit_n = credit - price;
          state_n  = (credit == price) ? ST_IDLE : ST_REFUND;
        end
      end
      ST_REFUND: begin
        if (credit <= CREDIT_W'(COIN_VALUE_5)) begin
          credit_n = '0;
          state_n  = ST_IDLE;
        end else begin
          credit_n = credit - CREDIT_W'(COIN_VALUE_5);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      credit            <= '0;
      vend.vend_product <= '0;
      vend.vend_valid   <= 1'b0;
      change_pulse      <= 1'b0;
      coin_reject       <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_n;
      credit            <= credit_n;
      vend.vend_product <= product_n;
      vend.vend_valid   <= (state_n == ST_VEND);
      change_pulse      <= (state == ST_REFUND) && (credit != '0);
      coin_reject       <= coin_any && (state != ST_COLLECT);
      busy              <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_vm_coin_credit.sv
// Scoreboarded bench for vm_coin_credit: directed purchases plus randomized transactions.
`timescale 1ns/1ps
module tb_vm_coin_credit;
  import vm_pkg::*;

  localparam int TO_CYCLES = 8;

  logic       clk, rst_n;
  logic       coin5, coin10, sel_valid, cancel;
  logic [1:0] sel_product;
  logic       change_pulse, coin_reject, busy;
  logic [4:0] credit;
  vm_state_e  dbg_state;

  vm_coin_credit_if vend_if ();

  vm_coin_credit #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin5        (coin5),
    .coin10       (coin10),
    .sel_valid    (sel_valid),
    .sel_product  (sel_product),
    .cancel       (cancel),
    .vend         (vend_if),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .credit       (credit),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [6:0] vend_q[$];   // {product, credit at handshake}
  logic [4:0] chg_q[$];    // credit remaining as each change pulse is shown
  logic [4:0] rej_q[$];    // credit shown with each coin_reject
  logic [1:0] cur_product;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int price_of(input logic [1:0] p);
    int tbl[4] = '{5, 10, 15, 20};
    return tbl[p];
  endfunction

  function automatic void expect_vend(input logic [1:0] p, input int total);
    vend_q.push_back({p, 5'(total)});
  endfunction

  function automatic void expect_refund(input int amount);
    for (int r = amount - 5; r >= 0; r -= 5) chg_q.push_back(5'(r));
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (vend_if.vend_valid) check("vend_product_hold", vend_if.vend_product, cur_product);
      if (vend_if.vend_valid && vend_if.vend_ready) begin
        if (vend_q.size() == 0) check("vend_unexpected", 1, 0);
        else begin
          logic [6:0] e;
          e = vend_q.pop_front();
          check("vend_product", vend_if.vend_product, e[6:5]);
          check("vend_credit", credit, e[4:0]);
        end
      end
      if (change_pulse) begin
        if (chg_q.size() == 0) check("change_unexpected", 1, 0);
        else check("change_credit", credit, chg_q.pop_front());
      end
      if (coin_reject) begin
        if (rej_q.size() == 0) check("reject_unexpected", 1, 0);
        else check("reject_credit", credit, rej_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input logic [1:0] p);
    cur_product = p;
    sel_valid   = 1'b1;
    sel_product = p;
    tick();
    sel_valid   = 1'b0;
  endtask

  task automatic drive(input bit c5, input bit c10, input bit cn);
    coin5 = c5; coin10 = c10; cancel = cn;
    tick();
    coin5 = 1'b0; coin10 = 1'b0; cancel = 1'b0;
  endtask

  task automatic vend_accept();
    vend_if.vend_ready = 1'b1;
    tick();
    vend_if.vend_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic check_vend_up();
    check("vend_valid_latency", vend_if.vend_valid, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    coin5 = 1'b0; coin10 = 1'b0; cancel = 1'b0;
    sel_valid = 1'b0; sel_product = 2'b00; cur_product = 2'b00;
    vend_if.vend_ready = 1'b0;
    repeat (3) tick();
    check("rst_credit", credit, 0);
    check("rst_vend_valid", vend_if.vend_valid, 0);
    check("rst_vend_product", vend_if.vend_product, 0);
    check("rst_change", change_pulse, 0);
    check("rst_reject", coin_reject, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // product 00, exact coin
    select(2'b00);
    check("busy_collect", busy, 1);
    expect_vend(2'b00, 5);
    drive(1, 0, 0);
    check_vend_up();
    vend_accept();
    wait_idle();
    check("t1_credit", credit, 0);

    // product 10, two coin10 -> one change pulse
    select(2'b10);
    drive(0, 1, 0);
    check("t2_credit_partial", credit, 10);
    expect_vend(2'b10, 20);
    expect_refund(5);
    drive(0, 1, 0);
    check_vend_up();
    vend_accept();
    wait_idle();

    // product 11, both coins then cancel -> three pulses, no vend
    select(2'b11);
    drive(1, 1, 0);
    check("t3_credit", credit, 15);
    expect_refund(15);
    drive(0, 0, 1);
    check("t3_no_vend", vend_if.vend_valid, 0);
    wait_idle();
    check("t3_credit_end", credit, 0);

    // product 01, downstream stalls, coin during stall is rejected
    select(2'b01);
    expect_vend(2'b01, 10);
    drive(0, 1, 0);
    check_vend_up();
    tick(); tick();
    rej_q.push_back(5'd10);
    drive(1, 0, 0);
    tick(); tick();
    check("t4_credit_stall", credit, 10);
    vend_accept();
    wait_idle();

    // coin in idle
    rej_q.push_back(5'd0);
    drive(1, 0, 0);
    tick();
    check("idle_coin_credit", credit, 0);

    // randomized purchases
    for (int t = 0; t < 40; t++) begin
      logic [1:0] p;
      int price, total, kind, sum;
      bit done;
      p = 2'($urandom_range(0, 3));
      price = price_of(p);
      total = 0;
      done = 0;
      select(p);
      while (!done) begin
        repeat ($urandom_range(0, 2)) tick();
        kind = $urandom_range(0, 2);
        sum = (kind == 0) ? 5 : (kind == 1) ? 10 : 15;
        total += sum;
        if ($urandom_range(0, 5) == 0) begin
          expect_refund(total);
          drive(kind != 1, kind != 0, 1);
          done = 1;
        end else if (total >= price) begin
          expect_vend(p, total);
          expect_refund(total - price);
          drive(kind != 1, kind != 0, 0);
          check_vend_up();
          for (int w = $urandom_range(0, 4); w > 0; w--) begin
            if ($urandom_range(0, 2) == 0) begin
              rej_q.push_back(5'(total));
              drive(1, 0, 0);
            end else tick();
          end
          vend_accept();
          done = 1;
        end else begin
          drive(kind != 1, kind != 0, 0);
        end
      end
      wait_idle();
      if ($urandom_range(0, 3) == 0) begin
        rej_q.push_back(5'd0);
        drive(0, 1, 0);
      end
    end
    tick(); tick();

`ifdef VM_COIN_TIMEOUT_EN
    begin
      int n = 0;
      select(2'b11);
      expect_refund(5);
      drive(1, 0, 0);
      while (busy && n < 40) begin
        tick();
        n++;
      end
      check("timeout_cycles", n, TO_CYCLES + 1);
      tick();
    end
`endif

    // reset in the middle of a collect
    select(2'b11);
    drive(0, 1, 0);
    check("mid_credit", credit, 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_credit", credit, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vend_valid", vend_if.vend_valid, 0);
    check("mid_rst_change", change_pulse, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_rst_credit", credit, 0);

    check("vend_q_empty", vend_q.size(), 0);
    check("chg_q_empty", chg_q.size(), 0);
    check("rej_q_empty", rej_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
